// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds PC, requests words from instruction memory,
// presents Instr/PC to execute and redirects on retire (seq, branch, JALR).
// Ports:
//   clk, reset                  clock, async active-high reset
//   imem_req, imem_addr         fetch request and address (address == PC)
//   imem_rvalid, imem_rdata     instruction memory response
//   Instr, PC, PCPlus4          held instruction, its address, link value
//   instr_valid, instr_ready    handshake with execute (retire = both high)
//   PCSrc, Jalr                 redirect controls sampled on retire
//   PCTarget, ALUResult         branch/JAL target and JALR target
//   fetch_err                   sticky misaligned-fetch flag
//   instret                     retired-instruction counter
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic        Jalr,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    output logic        fetch_err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        TRAP
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    logic        retire;
    logic [31:0] next_pc;
    logic [31:0] jalr_target;

    assign imem_req    = (state == REQ);
    assign instr_valid = (state == VALID);
    assign imem_addr   = PC;
    assign PCPlus4     = PC + 32'd4;
    assign retire      = instr_valid & instr_ready;

    // JALR clears bit 0 of rs1 + imm.
    assign jalr_target = ALUResult & 32'hFFFF_FFFE;

    always_comb begin
        next_pc = PCPlus4;
        if (PCSrc) begin
            next_pc = Jalr ? jalr_target : PCTarget;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            PC        <= RESET_PC;
            Instr     <= NOP;
            fetch_err <= 1'b0;
            instret   <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (imem_rvalid) begin
                        Instr <= imem_rdata;
                        state <= VALID;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        Instr <= imem_rdata;
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (retire) begin
                        PC      <= next_pc;
                        instret <= instret + 32'd1;
                        // A misaligned target never reaches memory.
                        if (next_pc[1:0] == 2'b00) begin
                            state <= REQ;
                        end else begin
                            state     <= TRAP;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// Second instance uses RESET_PC near the top of the address space.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        PCSrc;
    logic        Jalr;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] instret;

    logic        b_imem_req;
    logic [31:0] b_imem_addr;
    logic [31:0] b_Instr;
    logic [31:0] b_PC;
    logic [31:0] b_PCPlus4;
    logic        b_instr_valid;
    logic        b_fetch_err;
    logic [31:0] b_instret;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PCSrc(PCSrc), .Jalr(Jalr),
        .PCTarget(PCTarget), .ALUResult(ALUResult),
        .fetch_err(fetch_err), .instret(instret)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .reset(reset),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(b_Instr), .PC(b_PC), .PCPlus4(b_PCPlus4),
        .instr_valid(b_instr_valid), .instr_ready(instr_ready),
        .PCSrc(PCSrc), .Jalr(Jalr),
        .PCTarget(PCTarget), .ALUResult(ALUResult),
        .fetch_err(b_fetch_err), .instret(b_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic req_seen;
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        Jalr        = 1'b0;
        PCTarget    = 32'h0;
        ALUResult   = 32'h0;
        tick();
        tick();

        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", Instr, 32'h0000_0013);
        check("rst_pc", PC, 32'h0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_instret", instret, 32'd0);

        // Fetch with rvalid in the REQ cycle.
        reset = 1'b0;
        tick();
        check("r22_req", {31'd0, imem_req}, 32'd1);
        check("r22_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        check("r22_valid", {31'd0, instr_valid}, 32'd1);
        check("r22_instr", Instr, 32'h0050_0093);
        check("r22_pc", PC, 32'h0);
        check("r22_pc4", PCPlus4, 32'h4);
        check("r22_req_lo", {31'd0, imem_req}, 32'd0);

        // Delayed response, stalled execute, sequential retire.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("r23_req", {31'd0, imem_req}, 32'd1);
        tick();
        check("r23_wait_req", {31'd0, imem_req}, 32'd0);
        check("r23_wait_val", {31'd0, instr_valid}, 32'd0);
        tick();
        tick();
        check("r23_wait_pc", imem_addr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0010_0113;
        tick();
        check("r23_valid", {31'd0, instr_valid}, 32'd1);
        // Late response and redirect inputs must be ignored when not retiring.
        imem_rdata = 32'hBAD0_BAD0;
        PCSrc      = 1'b1;
        PCTarget   = 32'h0000_0200;
        tick();
        imem_rvalid = 1'b0;
        check("r23_hold_instr", Instr, 32'h0010_0113);
        check("r23_hold_pc", PC, 32'h0);
        tick();
        check("r23_hold_val", {31'd0, instr_valid}, 32'd1);
        check("r23_hold_ins2", Instr, 32'h0010_0113);
        instr_ready = 1'b1;
        PCSrc       = 1'b0;
        tick();
        instr_ready = 1'b0;
        check("r23_pc", PC, 32'h4);
        check("r23_instret", instret, 32'd1);
        check("r23_req", {31'd0, imem_req}, 32'd1);
        check("r23_addr", imem_addr, 32'h4);
        check("r23_pc4", PCPlus4, 32'h8);
        check("r23_val_lo", {31'd0, instr_valid}, 32'd0);

        // Step to PC=8, then branch and JALR redirects.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("r24_pc8", imem_addr, 32'h8);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        Jalr        = 1'b0;
        PCTarget    = 32'h0000_0040;
        ALUResult   = 32'h0000_0300;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        check("r24_br_addr", imem_addr, 32'h40);
        check("r24_br_req", {31'd0, imem_req}, 32'd1);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        Jalr        = 1'b1;
        PCTarget    = 32'h0000_0044;
        ALUResult   = 32'h0000_0101;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        Jalr        = 1'b0;
        check("r24_jalr_addr", imem_addr, 32'h100);
        check("r24_jalr_req", {31'd0, imem_req}, 32'd1);
        check("r24_instret", instret, 32'd4);

        // Misaligned target traps until reset.
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'h0000_0042;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        check("r25_err", {31'd0, fetch_err}, 32'd1);
        check("r25_pc", PC, 32'h42);
        check("r25_val", {31'd0, instr_valid}, 32'd0);
        req_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imem_rvalid = ~imem_rvalid;
            instr_ready = 1'b1;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) req_seen = 1'b1;
            tick();
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        check("r25_trap_quiet", {31'd0, req_seen}, 32'd0);
        check("r25_err_stuck", {31'd0, fetch_err}, 32'd1);
        reset = 1'b1;
        #1;
        check("r25_rst_err", {31'd0, fetch_err}, 32'd0);
        check("r25_rst_pc", PC, 32'h0);
        check("r25_rst_instret", instret, 32'd0);
        tick();

        // Reset during WAIT discards the outstanding fetch.
        reset = 1'b0;
        tick();
        tick();
        check("r26_wait", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("r26_instr", Instr, 32'h0000_0013);
        check("r26_val", {31'd0, instr_valid}, 32'd0);
        check("r26_req", {31'd0, imem_req}, 32'd1);
        tick();
        check("r26_instr2", Instr, 32'h0000_0013);
        check("r26_val2", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0513;
        tick();
        imem_rvalid = 1'b0;
        check("r26_new", Instr, 32'h0000_0513);
        check("r26_newval", {31'd0, instr_valid}, 32'd1);

        // PC wrap on the high-reset instance.
        reset = 1'b1;
        tick();
        check("r27_rst_pc", b_PC, 32'hFFFF_FFFC);
        check("r27_rst_pc4", b_PCPlus4, 32'h0);
        reset = 1'b0;
        tick();
        check("r27_addr", b_imem_addr, 32'hFFFF_FFFC);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("r27_pc", b_PC, 32'h0);
        check("r27_pc4", b_PCPlus4, 32'h4);
        check("r27_err", {31'd0, b_fetch_err}, 32'd0);
        check("r27_req", {31'd0, b_imem_req}, 32'd1);
        check("r27_instret", b_instret, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL take one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have one clock and reset; reset is asynchronous and active-high.
REQ-003 Port list, in this order:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; equals PC
- imem_rvalid  input  1  instruction memory read data valid
- imem_rdata  input  32  instruction word
- Instr  output  32  held instruction, feeding decode (op = Instr[6:0], funct3 = Instr[14:12], funct7b5 = Instr[30])
- PC  output  32  address of Instr
- PCPlus4  output  32  PC + 4, for JAL/JALR link
- instr_valid  output  1  Instr/PC are valid for execution
- instr_ready  input  1  execute accepts Instr this cycle (retire)
- PCSrc  input  1  taken branch or jump, from the controller
- Jalr  input  1  jump is JALR
- PCTarget  input  32  PC + immediate target
- ALUResult  input  32  rs1 + imm, the JALR target
- fetch_err  output  1  sticky misaligned-fetch flag
- instret  output  32  retired-instruction counter

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, VALID and TRAP.
REQ-005 IDLE SHALL move to REQ unconditionally on the next clock.
REQ-006 REQ SHALL drive imem_req=1 for exactly one cycle with imem_addr=PC.
- If imem_rvalid=1 in that same cycle: capture imem_rdata into Instr and go to VALID.
- Otherwise: go to WAIT.
REQ-007 WAIT SHALL hold imem_req=0 and PC stable; on imem_rvalid=1 it SHALL capture imem_rdata into Instr and go to VALID.
REQ-008 imem_rvalid SHALL be ignored in IDLE, VALID and TRAP; Instr SHALL NOT change in those states.
REQ-009 VALID SHALL assert instr_valid=1 combinationally from state; Instr and PC SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-010 Retire is instr_valid & instr_ready; on retire the next PC SHALL be:
- PCSrc=0: PC+4.
- PCSrc=1 and Jalr=0: PCTarget.
- PCSrc=1 and Jalr=1: {ALUResult[31:1],1'b0}.
REQ-011 On retire, PCSrc, Jalr, PCTarget and ALUResult SHALL be sampled in the retire cycle only; their values in any other cycle SHALL be ignored.
REQ-012 On retire with next-PC[1:0]==2'b00, the FSM SHALL load PC and go to REQ (a back-to-back fetch has a one-cycle gap after retire).
REQ-013 On retire with next-PC[1:0]!=2'b00, the FSM SHALL load PC, go to TRAP and set fetch_err=1.
REQ-014 TRAP SHALL be absorbing until reset: imem_req=0, instr_valid=0, fetch_err=1.
REQ-015 PCPlus4 SHALL equal PC+4 modulo 2^32 at all times; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
REQ-016 instret SHALL increment by 1 on each retire and wrap from 32'hFFFF_FFFF to 0.
REQ-017 imem_addr SHALL equal PC in every state.
REQ-018 Minimum latency from REQ to instr_valid is 1 cycle (rvalid in the REQ cycle); there is no maximum and no timeout.

Reset
REQ-019 While reset=1, asynchronously: state=IDLE, PC=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fetch_err=0, instret=0.
REQ-020 Reset asserted mid-WAIT SHALL discard the outstanding fetch; an imem_rvalid arriving after reset release while in IDLE SHALL be ignored.
REQ-021 The first imem_req after reset release SHALL occur in the second clock edge's cycle (IDLE then REQ), with imem_addr=RESET_PC.

Verification
REQ-022 Release reset, rvalid in the REQ cycle with rdata=32'h00500093 -> instr_valid=1 next cycle, Instr=32'h00500093, PC=0, PCPlus4=4.
REQ-023 Fetch with rvalid delayed 3 cycles, instr_ready held 0 for 2 cycles, then 1 with PCSrc=0 -> PC=4, instret=1, imem_req=1 one cycle later with imem_addr=4.
REQ-024 Retire at PC=8 with PCSrc=1, Jalr=0, PCTarget=32'h40 -> next imem_addr=32'h40; same case with Jalr=1, ALUResult=32'h0000_0101 -> next imem_addr=32'h100.
REQ-025 Retire with PCSrc=1, Jalr=0, PCTarget=32'h0000_0042 -> TRAP, fetch_err=1, imem_req stays 0 for 10 cycles; then reset -> fetch_err=0, PC=RESET_PC.
REQ-026 Assert reset in WAIT, then pulse imem_rvalid in IDLE with rdata=32'hDEADBEEF -> Instr remains 32'h00000013 and instr_valid stays 0 until the new fetch completes.
REQ-027 Preload PC=32'hFFFF_FFFC with RESET_PC, retire with PCSrc=0 -> PC=0, PCPlus4=4, fetch_err=0.
